// File: rtl/fps_pkg.sv
// Shared definitions for the frame-rate measurement block: FSM states and
// the default window and timeout lengths.
package fps_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } fps_state_t;

  localparam int unsigned CLOCKS_PER_SEC_DEF = 15998100;
  localparam int unsigned TIMEOUT_CLKS_DEF   = 400000;
  localparam int unsigned COUNT_W_DEF        = 7;

endpackage

// File: rtl/vsync_edge_sync.sv
// Multi-stage synchronizer for an asynchronous sync input, followed by a
// registered falling-edge detector. The pulse trails the pin by SYNC_STAGES+1.
module vsync_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK16MHz,
  input  logic RESET_N,
  input  logic SIG_IN,
  output logic SIG_SYNC,
  output logic SIG_FALL
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   fall_q;

  always_ff @(posedge CLK16MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SIG_IN};
      prev_q <= sync_q[SYNC_STAGES-1];
      fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign SIG_SYNC = sync_q[SYNC_STAGES-1];
  assign SIG_FALL = fall_q;

endmodule

// File: rtl/fps_window_ctrl.sv
// Frame-rate gate: counts synchronized VSYNC falling edges over back-to-back
// one-second windows and publishes each count through a VALID/ACK handshake.
module fps_window_ctrl
  import fps_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_SEC = CLOCKS_PER_SEC_DEF,
  parameter int unsigned COUNT_W        = COUNT_W_DEF,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CLKS   = TIMEOUT_CLKS_DEF
) (
  input  logic               CLK16MHz,
  input  logic               RESET_N,
  input  logic               ENABLE,
  input  logic               VSYNC,
  output logic [COUNT_W-1:0] FPS,
  output logic               FPS_VALID,
  input  logic               FPS_ACK,
  output logic               SATURATED,
  output logic               OVERRUN,
  output logic               SIGNAL_LOST,
  output logic               BLINK_PIN
);

  localparam int unsigned GATE_W = $clog2(CLOCKS_PER_SEC);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(CLOCKS_PER_SEC - 1);
  localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT_CLKS);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  logic sync_level_unused;
  logic edge_pulse;

  vsync_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_vsync_sync (
    .CLK16MHz(CLK16MHz),
    .RESET_N (RESET_N),
    .SIG_IN  (VSYNC),
    .SIG_SYNC(sync_level_unused),
    .SIG_FALL(edge_pulse)
  );

  fps_state_t         state_q, state_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [COUNT_W-1:0] edges_q, edges_d;
  logic               sat_q, sat_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [COUNT_W-1:0] fps_q, fps_d;
  logic               valid_q, valid_d;
  logic               sat_out_q, sat_out_d;
  logic               ovr_q, ovr_d;
  logic               blink_q, blink_d;

  logic [COUNT_W-1:0] edges_nx;
  logic               sat_nx;
  logic               publish;

  always_ff @(posedge CLK16MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      edges_q   <= '0;
      sat_q     <= 1'b0;
      to_q      <= '0;
      fps_q     <= '0;
      valid_q   <= 1'b0;
      sat_out_q <= 1'b0;
      ovr_q     <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      edges_q   <= edges_d;
      sat_q     <= sat_d;
      to_q      <= to_d;
      fps_q     <= fps_d;
      valid_q   <= valid_d;
      sat_out_q <= sat_out_d;
      ovr_q     <= ovr_d;
      blink_q   <= blink_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    edges_d   = edges_q;
    sat_d     = sat_q;
    to_d      = to_q;
    fps_d     = fps_q;
    valid_d   = valid_q;
    sat_out_d = sat_out_q;
    ovr_d     = ovr_q;
    blink_d   = blink_q;
    publish   = 1'b0;

    // Count including this cycle's edge, so a terminal-cycle edge is published
    edges_nx = (edge_pulse && (edges_q != CNT_MAX)) ? edges_q + 1'b1 : edges_q;
    sat_nx   = sat_q | (edge_pulse && (edges_q == CNT_MAX));

    if (!ENABLE) begin
      state_d = IDLE;
      gate_d  = '0;
      edges_d = '0;
      sat_d   = 1'b0;
      to_d    = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = MEASURE;
        MEASURE: begin
          if (edge_pulse) begin
            to_d = '0;
          end else if (to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
          end
          if (gate_q == GATE_LAST) begin
            publish   = 1'b1;
            gate_d    = '0;
            edges_d   = '0;
            sat_d     = 1'b0;
            fps_d     = edges_nx;
            sat_out_d = sat_nx;
            blink_d   = ~blink_q;
          end else begin
            gate_d  = gate_q + 1'b1;
            edges_d = edges_nx;
            sat_d   = sat_nx;
          end
        end
        default: state_d = IDLE;
      endcase

      // A same-cycle ACK is absorbed by the new publish and leaves OVERRUN alone
      if (publish) begin
        valid_d = 1'b1;
        if (valid_q && !FPS_ACK) begin
          ovr_d = 1'b1;
        end
      end else if (FPS_ACK && valid_q) begin
        valid_d = 1'b0;
        ovr_d   = 1'b0;
      end
    end
  end

  assign FPS         = fps_q;
  assign FPS_VALID   = valid_q;
  assign SATURATED   = sat_out_q;
  assign OVERRUN     = ovr_q;
  assign SIGNAL_LOST = (to_q == TO_MAX);
  assign BLINK_PIN   = blink_q;

endmodule

// File: tb/tb_fps_window_ctrl.sv
// Randomized bench for fps_window_ctrl with a window-level reference model
// and a few hand-computed expectations on short windows.
module tb_fps_window_ctrl;

  localparam int CPS  = 1000;
  localparam int TO   = 300;
  localparam int CW   = 7;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK16MHz = 1'b0;
  logic          RESET_N  = 1'b0;
  logic          ENABLE   = 1'b0;
  logic          VSYNC    = 1'b0;
  logic          FPS_ACK  = 1'b0;
  logic [CW-1:0] FPS;
  logic          FPS_VALID, SATURATED, OVERRUN, SIGNAL_LOST, BLINK_PIN;

  fps_window_ctrl #(
    .CLOCKS_PER_SEC(CPS),
    .COUNT_W       (CW),
    .SYNC_STAGES   (2),
    .TIMEOUT_CLKS  (TO)
  ) dut (
    .CLK16MHz   (CLK16MHz),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .VSYNC      (VSYNC),
    .FPS        (FPS),
    .FPS_VALID  (FPS_VALID),
    .FPS_ACK    (FPS_ACK),
    .SATURATED  (SATURATED),
    .OVERRUN    (OVERRUN),
    .SIGNAL_LOST(SIGNAL_LOST),
    .BLINK_PIN  (BLINK_PIN)
  );

  always #31 CLK16MHz = ~CLK16MHz;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Reference model: pin history, active-cycle count per window, quiet run
  logic [CW-1:0] m_fps;
  bit m_valid, m_sat, m_ovr, m_blink, m_prev_en, m_pub;
  int m_run, m_edges, m_quiet;
  bit vh[5];

  // VSYNC waveform generator
  int per, low, ph;
  bit hold_val;

  function automatic void model_reset();
    m_fps = '0; m_valid = 0; m_sat = 0; m_ovr = 0; m_blink = 0;
    m_prev_en = 0; m_pub = 0; m_run = 0; m_edges = 0; m_quiet = 0;
    for (int i = 0; i < 5; i++) vh[i] = 0;
  endfunction

  function automatic void model_step(input bit en, input bit vs, input bit ack);
    bit pulse, active;
    for (int i = 4; i > 0; i--) vh[i] = vh[i-1];
    vh[0] = vs;
    pulse  = vh[4] && !vh[3];
    active = m_prev_en && en;
    m_pub  = 0;
    m_quiet = (active && !pulse) ? m_quiet + 1 : 0;
    if (!en) begin
      m_run = 0; m_edges = 0; m_valid = 0; m_ovr = 0;
    end else begin
      if (active) begin
        m_run++;
        m_edges += int'(pulse);
        if (m_run == CPS) m_pub = 1;
      end
      if (m_pub) begin
        m_fps   = (m_edges > CMAX) ? CW'(CMAX) : CW'(m_edges);
        m_sat   = (m_edges > CMAX);
        m_blink = !m_blink;
        if (m_valid && !ack) m_ovr = 1;
        m_valid = 1;
        m_run   = 0;
        m_edges = 0;
      end else if (ack && m_valid) begin
        m_valid = 0;
        m_ovr   = 0;
      end
    end
    m_prev_en = en;
  endfunction

  function automatic bit vs_next();
    bit v;
    if (per == 0) return hold_val;
    v = ((ph % per) >= low);
    ph++;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge CLK16MHz) begin
    if (chk_en && RESET_N) begin
      vectors++;
      if (FPS !== m_fps || FPS_VALID !== m_valid || SATURATED !== m_sat ||
          OVERRUN !== m_ovr || SIGNAL_LOST !== (m_quiet >= TO) || BLINK_PIN !== m_blink) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t: got fps=%0d v=%b sat=%b ovr=%b lost=%b blink=%b, expected fps=%0d v=%b sat=%b ovr=%b lost=%b blink=%b",
                 $time, FPS, FPS_VALID, SATURATED, OVERRUN, SIGNAL_LOST, BLINK_PIN,
                 m_fps, m_valid, m_sat, m_ovr, (m_quiet >= TO), m_blink);
      end
    end
  end

  task automatic cycle(input bit en, input bit vs, input bit ack);
    ENABLE = en; VSYNC = vs; FPS_ACK = ack;
    @(posedge CLK16MHz);
    model_step(en, vs, ack);
    #1;
  endtask

  task automatic wait_pub(input string name, output int n);
    n = 0;
    do begin
      cycle(1, vs_next(), 0);
      n++;
    end while (!m_pub && n < 1100);
    if (!m_pub) chk({name, "_timeout"}, n, -1);
  endtask

  task automatic run_to(input string name, input int target);
    int n = 0;
    while (!(m_prev_en && m_run == target) && n < 1100) begin
      cycle(1, vs_next(), 0);
      n++;
    end
    if (n >= 1100) chk({name, "_timeout"}, n, -1);
  endtask

  initial begin
    int n;
    logic [CW-1:0] fps_hold;
    model_reset();
    per = 5; low = 2; ph = 0; hold_val = 0;
    repeat (3) @(posedge CLK16MHz);
    @(negedge CLK16MHz);
    RESET_N = 1'b1;
    chk("rst_fps", FPS, 0);
    chk("rst_valid", FPS_VALID, 0);
    chk("rst_sat", SATURATED, 0);
    chk("rst_ovr", OVERRUN, 0);
    chk("rst_lost", SIGNAL_LOST, 0);
    chk("rst_blink", BLINK_PIN, 0);
    chk_en = 1'b1;

    // Idle with VSYNC toggling and random ACKs
    for (int i = 0; i < 2000; i++) cycle(0, vs_next(), 1'($urandom % 2));
    chk("idle_fps", FPS, 0);
    chk("idle_valid", FPS_VALID, 0);
    chk("idle_blink", BLINK_PIN, 0);

    // Nominal window: period 17, low 3
    per = 17; low = 3; ph = 0;
    wait_pub("nominal", n);
    chk("nominal_latency", n, 1001);
    chk("nominal_fps_58_59", int'(FPS == 58 || FPS == 59), 1);
    chk("nominal_valid", FPS_VALID, 1);
    chk("nominal_blink", BLINK_PIN, 1);
    cycle(1, vs_next(), 1);
    chk("ack_clears_valid", FPS_VALID, 0);

    // Saturation then recovery
    per = 4; low = 2; ph = 0;
    wait_pub("sat", n);
    chk("sat_fps", FPS, 127);
    chk("sat_flag", SATURATED, 1);
    cycle(1, vs_next(), 1);
    per = 17; low = 3; ph = 0;
    wait_pub("unsat", n);
    chk("unsat_flag", SATURATED, 0);
    chk("unsat_fps_below_max", int'(FPS < 127), 1);

    // Overrun, then ACK on the publish cycle, then a clearing ACK
    wait_pub("overrun", n);
    chk("overrun_set", OVERRUN, 1);
    chk("overrun_valid", FPS_VALID, 1);
    run_to("term_ack", CPS - 1);
    cycle(1, vs_next(), 1);
    chk("simul_valid", FPS_VALID, 1);
    chk("simul_ovr_kept", OVERRUN, 1);
    cycle(1, vs_next(), 1);
    chk("ack_clears_ovr", OVERRUN, 0);
    chk("ack_clears_valid2", FPS_VALID, 0);

    // VSYNC held high: signal loss, then one edge landing on the terminal cycle
    per = 0; hold_val = 1;
    wait_pub("hold_hi", n);
    cycle(1, vs_next(), 1);
    run_to("lost_wait", 600);
    chk("lost_high", SIGNAL_LOST, 1);
    run_to("boundary_setup", CPS - 4);
    hold_val = 0;
    repeat (3) cycle(1, vs_next(), 0);
    chk("lost_before_edge", SIGNAL_LOST, 1);
    cycle(1, vs_next(), 0);
    chk("boundary_pub", int'(m_pub), 1);
    chk("boundary_fps", FPS, 1);
    chk("lost_cleared", SIGNAL_LOST, 0);
    n = 0;
    while (!SIGNAL_LOST && n < 400) begin
      cycle(1, vs_next(), 0);
      n++;
    end
    chk("lost_latency", n, TO);
    wait_pub("after_boundary", n);
    chk("next_window_fps", FPS, 0);

    // Abort mid-window, then re-enable
    per = 17; low = 3; ph = 0;
    run_to("abort_point", 500);
    fps_hold = FPS;
    repeat (10) cycle(0, vs_next(), 0);
    chk("abort_valid", FPS_VALID, 0);
    chk("abort_lost", SIGNAL_LOST, 0);
    chk("abort_ovr", OVERRUN, 0);
    chk("abort_fps_held", FPS, fps_hold);
    wait_pub("reenable", n);
    chk("reenable_latency", n, 1001);
    chk("reenable_fps_58_59", int'(FPS == 58 || FPS == 59), 1);

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 6000; i++) begin
      if (i % 700 == 0) begin
        per = ($urandom % 6 == 0) ? 0 : int'($urandom_range(3, 40));
        if (per != 0) low = int'($urandom_range(1, per - 1));
        hold_val = 1'($urandom % 2);
        ph = 0;
      end
      if (i == 3100) begin
        #5 RESET_N = 1'b0;
        #1;
        chk("midrst_fps", FPS, 0);
        chk("midrst_valid", FPS_VALID, 0);
        chk("midrst_blink", BLINK_PIN, 0);
        model_reset();
        repeat (2) @(posedge CLK16MHz);
        @(negedge CLK16MHz);
        RESET_N = 1'b1;
      end
      cycle(($urandom % 400) != 0, vs_next(), ($urandom % 6) == 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
